// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite rotate/mirror writer: FSM states,
// sprite geometry and quarter-turn codes.
package sprite_pkg;

  localparam int SPRITE_W     = 16;
  localparam int SPRITE_BYTES = 32;
  localparam int COORD_W      = $clog2(SPRITE_W);
  localparam int CNT_W        = $clog2(SPRITE_BYTES);
  localparam int BUF_W        = SPRITE_BYTES * 8;

  localparam logic [1:0] ROT_0   = 2'd0;
  localparam logic [1:0] ROT_90  = 2'd1;
  localparam logic [1:0] ROT_180 = 2'd2;
  localparam logic [1:0] ROT_270 = 2'd3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_SETUP = 3'd1,
    LOAD_FETCH = 3'd2,
    WRITE      = 3'd3,
    DONE       = 3'd4
  } state_t;

endpackage

// File: rtl/sprite_pixel_map.sv
// Maps one output pixel (x,y) back to the source pixel it is copied from.
// Mirroring is applied to the output coordinate first, then the quarter turn.
module sprite_pixel_map
  import sprite_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         quarter,
  input  logic               hmirror,
  input  logic               vmirror,
  output logic [COORD_W-1:0] src_x,
  output logic [COORD_W-1:0] src_y
);

  logic [COORD_W-1:0] xm_s;
  logic [COORD_W-1:0] ym_s;

  // Mirror then rotate; 15-v is simply the bitwise complement of v.
  always_comb begin
    xm_s  = hmirror ? ~x : x;
    ym_s  = vmirror ? ~y : y;
    src_x = xm_s;
    src_y = ym_s;
    case (quarter)
      ROT_0: begin
        src_x = xm_s;
        src_y = ym_s;
      end
      ROT_90: begin
        src_x = ym_s;
        src_y = ~xm_s;
      end
      ROT_180: begin
        src_x = ~xm_s;
        src_y = ~ym_s;
      end
      ROT_270: begin
        src_x = ~ym_s;
        src_y = xm_s;
      end
      default: begin
        src_x = xm_s;
        src_y = ym_s;
      end
    endcase
  end

endmodule

// File: rtl/sprite_rotate_writer.sv
// Copies a 16x16 bitmap from ROM into sprite RAM, rotated by quarter turns
// and optionally mirrored. Loads all 32 source bytes into a local buffer,
// then writes the transformed bytes in ascending address order whenever
// the write window is open.
module sprite_rotate_writer
  import sprite_pkg::*;
#(
  parameter int BITMAP_BITS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BITMAP_BITS-1:0] bitmap_num,
  input  logic [1:0]             quarter,
  input  logic                   hmirror,
  input  logic                   vmirror,
  output logic [BITMAP_BITS+4:0] src_addr,
  input  logic [7:0]             src_bits,
  output logic [4:0]             dst_addr,
  output logic [7:0]             dst_data,
  output logic                   dst_we,
  input  logic                   wr_window,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BITMAP_BITS-1:0] bitmap_q, bitmap_d;
  logic [1:0]             quarter_q, quarter_d;
  logic                   hmirror_q, hmirror_d;
  logic                   vmirror_q, vmirror_d;
  logic [BITMAP_BITS+4:0] src_addr_q, src_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [BUF_W-1:0]       buf_q, buf_d;
  logic [7:0]             map_byte_s;
  logic                   dst_we_s;
  logic [4:0]             dst_addr_s;
  logic [7:0]             dst_data_s;

  // One pixel mapper per bit of the byte currently being written.
  for (genvar g = 0; g < 8; g++) begin : g_map
    localparam logic [2:0] BIT_IDX = 3'(g);
    logic [COORD_W-1:0] sx_s;
    logic [COORD_W-1:0] sy_s;
    sprite_pixel_map u_map (
      .x       ({cnt_q[0], BIT_IDX}),
      .y       (cnt_q[4:1]),
      .quarter (quarter_q),
      .hmirror (hmirror_q),
      .vmirror (vmirror_q),
      .src_x   (sx_s),
      .src_y   (sy_s)
    );
    assign map_byte_s[g] = buf_q[{sy_s, sx_s}];
  end

  // Next-state, counter, buffer fill and write-port decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitmap_d   = bitmap_q;
    quarter_d  = quarter_q;
    hmirror_d  = hmirror_q;
    vmirror_d  = vmirror_q;
    src_addr_d = src_addr_q;
    buf_d      = buf_q;
    dst_we_s   = 1'b0;
    dst_addr_s = 5'd0;
    dst_data_s = 8'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bitmap_d  = bitmap_num;
          quarter_d = quarter;
          hmirror_d = hmirror;
          vmirror_d = vmirror;
          cnt_d     = 5'd0;
          state_d   = LOAD_SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_SETUP: begin
        src_addr_d = {bitmap_q, cnt_q};
        state_d    = LOAD_FETCH;
      end
      LOAD_FETCH: begin
        buf_d[{cnt_q, 3'b000} +: 8] = src_bits;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(SPRITE_BYTES - 1)) begin
          state_d = WRITE;
        end else begin
          state_d = LOAD_SETUP;
        end
      end
      WRITE: begin
        // Address and data stay presented while stalled; only the strobe drops.
        dst_addr_s = cnt_q;
        dst_data_s = map_byte_s;
        if (wr_window) begin
          dst_we_s = 1'b1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'(SPRITE_BYTES - 1)) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else begin
          dst_we_s = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == LOAD_SETUP) || (state_d == LOAD_FETCH) || (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      bitmap_q   <= '0;
      quarter_q  <= 2'd0;
      hmirror_q  <= 1'b0;
      vmirror_q  <= 1'b0;
      src_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitmap_q   <= bitmap_d;
      quarter_q  <= quarter_d;
      hmirror_q  <= hmirror_d;
      vmirror_q  <= vmirror_d;
      src_addr_q <= src_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Bitmap buffer: deliberately not reset, it is fully reloaded per operation.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign src_addr = src_addr_q;
  assign dst_we   = dst_we_s;
  assign dst_addr = dst_addr_s;
  assign dst_data = dst_data_s;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sprite_rotate_writer.sv
// Self-checking bench for sprite_rotate_writer: a ROM and RAM model around the
// DUT, a coordinate-level reference for the transformed sprite and a
// cycle-level expectation of write strobes, busy and done.
module tb_sprite_rotate_writer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] bitmap_num;
  logic [1:0] quarter;
  logic       hmirror;
  logic       vmirror;
  logic [7:0] src_addr;
  logic [7:0] src_bits;
  logic [4:0] dst_addr;
  logic [7:0] dst_data;
  logic       dst_we;
  logic       wr_window;
  logic       busy;
  logic       done;

  logic [7:0] rom [0:255];
  logic [7:0] ram [0:31];

  int tests;
  int fails;

  typedef struct {
    int  bitmap;
    int  quarter;
    int  h;
    int  v;
    int  mode;       // 0 window high, 1 stall after 5th write, 2 random window
    int  stall_len;
    bit  poke;       // pulse start with a different quarter during WRITE
    int  exp_done;   // expected done cycle, 0 = derive from window pattern only
  } op_t;

  op_t tbl [0:9];

  sprite_rotate_writer #(.BITMAP_BITS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bitmap_num (bitmap_num),
    .quarter    (quarter),
    .hmirror    (hmirror),
    .vmirror    (vmirror),
    .src_addr   (src_addr),
    .src_bits   (src_bits),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data),
    .dst_we     (dst_we),
    .wr_window  (wr_window),
    .busy       (busy),
    .done       (done)
  );

  assign src_bits = rom[src_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: output pixel (X,Y) comes from source (sx,sy) by the mirror/turn rules.
  function automatic logic [7:0] model_byte(input int b, input int q, input int h,
                                            input int v, input int a);
    logic [7:0] r;
    logic [7:0] rb;
    int x, y, xp, yp, sx, sy;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      x  = (a % 2) * 8 + i;
      y  = a / 2;
      xp = (h != 0) ? 15 - x : x;
      yp = (v != 0) ? 15 - y : y;
      case (q)
        0:       begin sx = xp;      sy = yp;      end
        1:       begin sx = yp;      sy = 15 - xp; end
        2:       begin sx = 15 - xp; sy = 15 - yp; end
        default: begin sx = 15 - yp; sy = xp;      end
      endcase
      rb   = rom[b * 32 + sy * 2 + sx / 8];
      r[i] = rb[sx % 8];
    end
    return r;
  endfunction

  task automatic run_op(input op_t op);
    int  c;
    int  writes;
    int  exp_writes;
    int  exp_done;
    int  stall_left;
    int  done_at;
    bit  win;
    bit  exp_we;
    for (int i = 0; i < 32; i++) ram[i] = 8'h00;
    @(negedge clk);
    bitmap_num = 3'(op.bitmap);
    quarter    = 2'(op.quarter);
    hmirror    = 1'(op.h);
    vmirror    = 1'(op.v);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    bitmap_num = 3'($urandom);
    quarter    = 2'($urandom);
    hmirror    = 1'($urandom);
    vmirror    = 1'($urandom);
    c = 0; writes = 0; exp_writes = 0; exp_done = -1; done_at = -1;
    stall_left = op.stall_len;
    while (done_at < 0 && c < 400) begin
      @(negedge clk);
      c++;
      case (op.mode)
        1: begin
          win = !(writes == 5 && stall_left > 0);
          if (!win) stall_left--;
        end
        2:       win = ($urandom_range(0, 3) != 0);
        default: win = 1'b1;
      endcase
      wr_window = win;
      if (op.poke && c == 70) begin
        start   = 1'b1;
        quarter = 2'(op.quarter + 1);
      end else begin
        start = 1'b0;
      end
      #1;
      exp_we = (c >= 65) && (exp_writes < 32) && win;
      check("dst_we", 32'(dst_we), 32'(exp_we));
      if (c >= 65 && exp_writes < 32 && !win) check("stall_addr", 32'(dst_addr), 32'(exp_writes));
      if (dst_we) begin
        check("dst_addr", 32'(dst_addr), 32'(writes));
        ram[dst_addr] = dst_data;
        writes++;
      end
      if (exp_we) begin
        exp_writes++;
        if (exp_writes == 32) exp_done = c + 1;
      end
      check("busy", 32'(busy), 32'(exp_done < 0 || c < exp_done));
      check("done", 32'(done), 32'(c == exp_done));
      if (done) done_at = c;
    end
    if (done_at < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: no done within %0d cycles", c);
    end
    if (op.exp_done > 0) check("done_cycle", 32'(done_at), 32'(op.exp_done));
    check("write_count", 32'(writes), 32'd32);
    for (int a = 0; a < 32; a++)
      check("ram_byte", 32'(ram[a]), 32'(model_byte(op.bitmap, op.quarter, op.h, op.v, a)));
    @(negedge clk);
    start     = 1'b0;
    wr_window = 1'b1;
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    // bitmap 0 row 0 = 0x0780
    rom[0] = 8'h80;
    rom[1] = 8'h07;
    // bitmap 1: single pixel at (0,0)
    for (int i = 32; i < 64; i++) rom[i] = 8'h00;
    rom[32] = 8'h01;

    //             bmp q h v mode stall poke exp_done
    tbl[0] = '{0, 0, 0, 0, 0, 0,  1'b0, 97};
    tbl[1] = '{0, 0, 1, 0, 0, 0,  1'b0, 97};
    tbl[2] = '{1, 1, 0, 0, 0, 0,  1'b0, 97};
    tbl[3] = '{1, 2, 0, 0, 0, 0,  1'b0, 97};
    tbl[4] = '{1, 3, 0, 0, 0, 0,  1'b0, 97};
    tbl[5] = '{2, 1, 1, 1, 1, 10, 1'b0, 107};
    tbl[6] = '{3, 2, 0, 1, 0, 0,  1'b1, 97};
    tbl[7] = '{4, 3, 1, 0, 0, 0,  1'b0, 97};
    tbl[8] = '{5, 0, 0, 1, 2, 0,  1'b0, 0};
    tbl[9] = '{6, 1, 1, 0, 2, 0,  1'b0, 0};

    reset = 1'b1; start = 1'b0; wr_window = 1'b1;
    bitmap_num = 3'd0; quarter = 2'd0; hmirror = 1'b0; vmirror = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_src_addr", 32'(src_addr), 32'd0);
    check("rst_dst_addr", 32'(dst_addr), 32'd0);
    check("rst_dst_data", 32'(dst_data), 32'd0);
    check("rst_dst_we",   32'(dst_we),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    reset = 1'b0;

    for (int t = 0; t < 10; t++) begin
      run_op(tbl[t]);
      if (t == 0) begin
        check("q0_addr0", 32'(ram[0]), 32'h80);
        check("q0_addr1", 32'(ram[1]), 32'h07);
      end
      if (t == 1) begin
        check("hm_addr0", 32'(ram[0]), 32'hE0);
        check("hm_addr1", 32'(ram[1]), 32'h01);
      end
      if (t == 2) check("q1_addr1",  32'(ram[1]),  32'h80);
      if (t == 3) check("q2_addr31", 32'(ram[31]), 32'h80);
      if (t == 4) check("q3_addr30", 32'(ram[30]), 32'h01);
    end

    // Reset during LOAD_FETCH aborts at once; a fresh start then runs normally.
    @(negedge clk);
    bitmap_num = 3'd7; quarter = 2'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy),     32'd0);
    check("mid_rst_we",    32'(dst_we),   32'd0);
    check("mid_rst_src",   32'(src_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op('{7, 2, 0, 1, 0, 0, 1'b0, 97});

    // Random operations against the reference model.
    for (int r = 0; r < 5; r++) begin
      op_t op;
      op.bitmap    = int'($urandom_range(0, 7));
      op.quarter   = int'($urandom_range(0, 3));
      op.h         = int'($urandom_range(0, 1));
      op.v         = int'($urandom_range(0, 1));
      op.mode      = int'($urandom_range(0, 2));
      op.stall_len = int'($urandom_range(1, 6));
      op.poke      = 1'($urandom_range(0, 1));
      op.exp_done  = 0;
      run_op(op);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
